burst_seq_gen: RTL and testbench

- Parametrised multi-channel stimulus sequencer for block-level benches and on-chip self-test.
- Emits a burst of counter values on NCH channels under a valid/ready handshake, then idles for a programmable gap, then signals completion.
- Generalises the single 4-bit, fixed-length, fixed-idle counting pattern to configurable width, channel count, length, gap, step and direction, with backpressure and optional looping.

---
 rtl/burst_seq_gen.sv | 183 ++++++++++++++++++
 tb/tb_burst_seq_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_seq_gen.sv
// Multi-channel burst/gap counter sequencer with valid/ready output handshake.
// Optional BURST_SEQ_GEN_SAT_EN: per-channel saturating steps instead of modulo wrap.
module burst_seq_gen #(
    parameter int unsigned DW   = 4,
    parameter int unsigned NCH  = 2,
    parameter int unsigned LENW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic              dir,
    input  logic [DW-1:0]     step,
    input  logic [NCH*DW-1:0] init,
    input  logic [LENW-1:0]   burst_len,
    input  logic [LENW-1:0]   gap_len,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NCH*DW-1:0] o_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LENW-1:0]     cnt_q, cnt_d;
    logic                cfg_loop_q, cfg_loop_d;
    logic                cfg_dir_q, cfg_dir_d;
    logic [DW-1:0]       cfg_step_q, cfg_step_d;
    logic [NCH*DW-1:0]   cfg_init_q, cfg_init_d;
    logic [LENW-1:0]     cfg_burst_len_q, cfg_burst_len_d;
    logic [LENW-1:0]     cfg_gap_len_q, cfg_gap_len_d;
    logic                o_valid_q, o_valid_d;
    logic [NCH*DW-1:0]   o_data_q, o_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // A run may skip the burst and/or the gap when their lengths are zero.
    function automatic state_t entry_state(input logic [LENW-1:0] bl,
                                           input logic [LENW-1:0] gl);
        if (bl != '0) begin
            return S_BURST;
        end else if (gl != '0) begin
            return S_GAP;
        end else begin
            return S_DONE;
        end
    endfunction

    function automatic logic [NCH*DW-1:0] step_all(input logic [NCH*DW-1:0] cur,
                                                   input logic [DW-1:0]     stp,
                                                   input logic              down);
        logic [NCH*DW-1:0] nxt;
        logic [DW-1:0]     ch;
        nxt = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            ch = cur[k*DW +: DW];
`ifdef BURST_SEQ_GEN_SAT_EN
            // ch + stp overflows exactly when ch exceeds (2^DW-1) - stp, i.e. ~stp.
            if (down) begin
                ch = (stp > ch) ? '0 : ch - stp;
            end else begin
                ch = (ch > ~stp) ? '1 : ch + stp;
            end
`else
            ch = down ? ch - stp : ch + stp;
`endif
            nxt[k*DW +: DW] = ch;
        end
        return nxt;
    endfunction

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cfg_loop_d      = cfg_loop_q;
        cfg_dir_d       = cfg_dir_q;
        cfg_step_d      = cfg_step_q;
        cfg_init_d      = cfg_init_q;
        cfg_burst_len_d = cfg_burst_len_q;
        cfg_gap_len_d   = cfg_gap_len_q;
        o_data_d        = o_data_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    cfg_loop_d      = loop;
                    cfg_dir_d       = dir;
                    cfg_step_d      = step;
                    cfg_init_d      = init;
                    cfg_burst_len_d = burst_len;
                    cfg_gap_len_d   = gap_len;
                    o_data_d        = init;
                    cnt_d           = '0;
                    state_d         = entry_state(burst_len, gap_len);
                end
            end
            S_BURST: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (i_ready) begin
                    o_data_d = step_all(o_data_q, cfg_step_q, cfg_dir_q);
                    if (cnt_q == cfg_burst_len_q - LENW'(1)) begin
                        cnt_d   = '0;
                        state_d = (cfg_gap_len_q == '0) ? S_DONE : S_GAP;
                    end else begin
                        cnt_d = cnt_q + LENW'(1);
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == cfg_gap_len_q - LENW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + LENW'(1);
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (cfg_loop_q) begin
                    o_data_d = cfg_init_q;
                    cnt_d    = '0;
                    state_d  = entry_state(cfg_burst_len_q, cfg_gap_len_q);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flag outputs follow the next state so they line up with it after the edge.
        o_valid_d = (state_d == S_BURST);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            cfg_loop_q      <= 1'b0;
            cfg_dir_q       <= 1'b0;
            cfg_step_q      <= '0;
            cfg_init_q      <= '0;
            cfg_burst_len_q <= '0;
            cfg_gap_len_q   <= '0;
            o_valid_q       <= 1'b0;
            o_data_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cfg_loop_q      <= cfg_loop_d;
            cfg_dir_q       <= cfg_dir_d;
            cfg_step_q      <= cfg_step_d;
            cfg_init_q      <= cfg_init_d;
            cfg_burst_len_q <= cfg_burst_len_d;
            cfg_gap_len_q   <= cfg_gap_len_d;
            o_valid_q       <= o_valid_d;
            o_data_q        <= o_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_burst_seq_gen.sv
// Self-checking bench for burst_seq_gen: vector table, directed corner sequences,
// and randomized runs against a closed-form beat model (honours BURST_SEQ_GEN_SAT_EN).
module tb_burst_seq_gen;

    localparam int unsigned DW   = 4;
    localparam int unsigned NCH  = 2;
    localparam int unsigned LENW = 8;
    localparam int unsigned W    = NCH * DW;
    localparam int          MAXV = (1 << DW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, stop, loop, dir, i_ready;
    logic [DW-1:0]   step;
    logic [W-1:0]    init;
    logic [LENW-1:0] burst_len, gap_len;
    logic            o_valid, busy, done;
    logic [W-1:0]    o_data;

    burst_seq_gen #(.DW(DW), .NCH(NCH), .LENW(LENW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .dir(dir),
        .step(step), .init(init), .burst_len(burst_len), .gap_len(gap_len),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Beat i of a run, per channel: init -/+ i*step, wrapped or clamped.
    function automatic logic [W-1:0] exp_beat(input logic [W-1:0] ini, input logic [DW-1:0] stp,
                                              input logic dn, input int i);
        logic [W-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            v = int'(ini[k*DW +: DW]) + (dn ? -i : i) * int'(stp);
`ifdef BURST_SEQ_GEN_SAT_EN
            if (v < 0) v = 0;
            if (v > MAXV) v = MAXV;
`else
            v = ((v % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
`endif
            r[k*DW +: DW] = DW'(v);
        end
        return r;
    endfunction

    task automatic cfg(input logic [W-1:0] ini, input logic [DW-1:0] stp, input logic dn,
                       input int bl, input int gl, input logic lp);
        init = ini; step = stp; dir = dn; loop = lp;
        burst_len = LENW'(bl); gap_len = LENW'(gl);
    endtask

    task automatic scramble_inputs();
        start     = 1'($urandom_range(1));
        loop      = 1'($urandom_range(1));
        dir       = 1'($urandom_range(1));
        step      = DW'($urandom);
        init      = W'($urandom);
        burst_len = LENW'($urandom);
        gap_len   = LENW'($urandom);
    endtask

    typedef struct {
        logic [W-1:0]      init;
        logic [DW-1:0]     step;
        logic              dir;
        int                bl;
        int                gl;
        int                nchk;
        logic [3:0][W-1:0] beats;
        int                n_done;
    } vec_t;

    function automatic vec_t mk(input logic [W-1:0] ini, input logic [DW-1:0] stp, input logic dn,
                                input int bl, input int gl, input int nchk,
                                input logic [W-1:0] b0, input logic [W-1:0] b1,
                                input logic [W-1:0] b2, input logic [W-1:0] b3, input int nd);
        vec_t v;
        v.init = ini; v.step = stp; v.dir = dn; v.bl = bl; v.gl = gl; v.nchk = nchk;
        v.beats = {b3, b2, b1, b0};
        v.n_done = nd;
        return v;
    endfunction

`ifdef BURST_SEQ_GEN_SAT_EN
    localparam logic [W-1:0] WRAP_B2 = 8'h2F, WRAP_B3 = 8'h3F, DW_B1 = 8'h00, DW_B2 = 8'h00;
`else
    localparam logic [W-1:0] WRAP_B2 = 8'h20, WRAP_B3 = 8'h31, DW_B1 = 8'hFE, DW_B2 = 8'hCB;
`endif

    localparam int NT = 7;
    vec_t tbl [NT];

    // Model-driven run with random backpressure; mid-run input changes must be ignored.
    task automatic model_run(input logic [W-1:0] ini, input logic [DW-1:0] stp, input logic dn,
                             input int bl, input int gl, input int reps, input int rdy_pct);
        logic [W-1:0] last;
        int  waits;
        bit  acc;
        cfg(ini, stp, dn, bl, gl, reps > 1);
        stop = 1'b0; start = 1'b1; i_ready = 1'b0;
        tick();
        start = 1'b0;
        last = exp_beat(ini, stp, dn, bl);
        for (int r = 0; r < reps; r++) begin
            for (int b = 0; b < bl; b++) begin
                waits = 0;
                acc   = 1'b0;
                while (!acc) begin
                    acc = (waits >= 6) || ($urandom_range(99) < rdy_pct);
                    scramble_inputs();
                    i_ready = acc;
                    chk("rnd_beat_valid", o_valid, 1);
                    chk("rnd_beat_data", o_data, exp_beat(ini, stp, dn, b));
                    chk("rnd_beat_done", done, 0);
                    tick();
                    waits++;
                end
            end
            for (int g = 0; g < gl; g++) begin
                scramble_inputs();
                i_ready = 1'($urandom_range(1));
                chk("rnd_gap_valid", o_valid, 0);
                chk("rnd_gap_data", o_data, last);
                chk("rnd_gap_busy", busy, 1);
                chk("rnd_gap_done", done, 0);
                tick();
            end
            scramble_inputs();
            chk("rnd_done", done, 1);
            chk("rnd_done_valid", o_valid, 0);
            chk("rnd_done_busy", busy, 1);
            if (r == reps - 1 && reps > 1) stop = 1'b1;
            tick();
        end
        start = 1'b0; stop = 1'b0; i_ready = 1'b0;
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_valid", o_valid, 0);
        chk("rnd_idle_done", done, 0);
        chk("rnd_idle_data", o_data, last);
    endtask

    int nv, nb, n;
    bit ph;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = mk(8'h30, 4'd1, 1'b0, 10, 10, 4, 8'h30, 8'h41, 8'h52, 8'h63, 20);
        tbl[1] = mk(8'h0E, 4'd1, 1'b0, 4, 1, 4, 8'h0E, 8'h1F, WRAP_B2, WRAP_B3, 5);
        tbl[2] = mk(8'h55, 4'd2, 1'b1, 3, 2, 3, 8'h55, 8'h33, 8'h11, 8'h00, 5);
        tbl[3] = mk(8'h12, 4'd1, 1'b0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        tbl[4] = mk(8'hA7, 4'd3, 1'b0, 2, 0, 2, 8'hA7, 8'hDA, 8'h00, 8'h00, 2);
        tbl[5] = mk(8'h21, 4'd3, 1'b1, 3, 0, 3, 8'h21, DW_B1, DW_B2, 8'h00, 3);
        tbl[6] = mk(8'h44, 4'd1, 1'b0, 0, 3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3);

        rst = 1'b1; start = 1'b0; stop = 1'b0; i_ready = 1'b0;
        cfg('0, '0, 1'b0, 0, 0, 1'b0);
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int t = 0; t < NT; t++) begin
            cfg(tbl[t].init, tbl[t].step, tbl[t].dir, tbl[t].bl, tbl[t].gl, 1'b0);
            start = 1'b1; i_ready = 1'b1;
            tick();
            start = 1'b0;
            nv = 0; n = 0;
            while (!done && n < 100) begin
                if (o_valid) begin
                    if (nv < tbl[t].nchk) chk("tbl_beat", o_data, tbl[t].beats[nv]);
                    nv++;
                end
                tick();
                n++;
            end
            chk("tbl_valid_cnt", nv, tbl[t].bl);
            chk("tbl_done_lat", n, tbl[t].n_done);
            tick();
            chk("tbl_idle_busy", busy, 0);
            chk("tbl_idle_done", done, 0);
        end

        cfg(8'h30, 4'd1, 1'b0, 10, 10, 1'b0);
        start = 1'b1; i_ready = 1'b0;
        tick();
        start = 1'b0;
        nv = 0; nb = 0; ph = 1'b1;
        while (o_valid && nv < 40) begin
            i_ready = ph;
            chk("bp_data", o_data, exp_beat(8'h30, 4'd1, 1'b0, nb));
            if (ph) nb++;
            ph = !ph;
            nv++;
            tick();
        end
        chk("bp_valid_cycles", nv, 19);
        chk("bp_beats", nb, 10);
        n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk("bp_gap_len", n, 10);
        tick();
        chk("bp_idle_busy", busy, 0);

        cfg(8'h55, 4'd2, 1'b1, 3, 2, 1'b1);
        start = 1'b1; i_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < 3; b++) begin
                chk("loop_valid", o_valid, 1);
                chk("loop_data", o_data, exp_beat(8'h55, 4'd2, 1'b1, b));
                tick();
            end
            for (int g = 0; g < 2; g++) begin
                chk("loop_gap_valid", o_valid, 0);
                chk("loop_gap_done", done, 0);
                tick();
            end
            chk("loop_done", done, 1);
            tick();
        end
        chk("loop_rep3_b0", o_data, 8'h55);
        tick();
        chk("loop_rep3_b1", o_data, 8'h33);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", o_valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        chk("stop_data_hold", o_data, 8'h33);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stop_no_done", done, 0);
        end

        cfg(8'h30, 4'd1, 1'b0, 5, 5, 1'b0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_valid", o_valid, 0);
        tick();
        chk("startstop_busy2", busy, 0);

        cfg(8'h30, 4'd1, 1'b0, 10, 10, 1'b0);
        start = 1'b1; i_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("rstmid_beat4", o_data, 8'h74);
        rst = 1'b1;
        #2;
        chk("rstmid_valid", o_valid, 0);
        chk("rstmid_data", o_data, 0);
        chk("rstmid_busy", busy, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_idle_busy", busy, 0);
            chk("rstmid_idle_valid", o_valid, 0);
        end

        for (int i = 0; i < 30; i++) begin
            model_run(W'($urandom), DW'($urandom), 1'($urandom_range(1)),
                      int'($urandom_range(7)), int'($urandom_range(4)),
                      ($urandom_range(3) == 0) ? 2 : 1, 60);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
